// File: rtl/psdu_deframer_if.sv
// rtl/psdu_deframer_if.sv - PSDU byte output handshake bundle.
interface psdu_deframer_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_out, output byte_valid, input byte_ready);
    modport slave  (input byte_out, input byte_valid, output byte_ready);
endinterface

// File: rtl/psdu_deframer.sv
// rtl/psdu_deframer.sv - SERVICE strip/check and LSB-first PSDU byte packer after the descrambler.
module psdu_deframer #(
    parameter int LEN_W        = 12,
    parameter int SERVICE_BITS = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        psdu_len,
    input  logic                    enable,
    input  logic                    bit_in,
    psdu_deframer_if.master         byte_if,
    output logic [SERVICE_BITS-1:0] service_out,
    output logic                    service_err,
    output logic                    overflow,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SERVICE_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SERVICE,
        S_DATA
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] byte_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       asm_q;
    logic [7:0]       asm_next;
    logic [7:0]       byte_q;
    logic             valid_q;
    logic             take_bit;
    logic             svc_last;
    logic             byte_done;
    logic             frame_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start outranks everything; the bit presented alongside it is never consumed
    always_comb begin
        state_next = state;
        take_bit   = 1'b0;
        svc_last   = 1'b0;
        byte_done  = 1'b0;
        frame_end  = 1'b0;
        asm_next   = asm_q;
        asm_next[bit_cnt[2:0]] = bit_in;
        if (start) begin
            state_next = S_SERVICE;
        end else begin
            case (state)
                S_SERVICE: begin
                    if (enable) begin
                        take_bit = 1'b1;
                        if (bit_cnt == CNT_W'(SERVICE_BITS - 1)) begin
                            svc_last = 1'b1;
                            if (len_q == '0) begin
                                state_next = S_IDLE;
                                frame_end  = 1'b1;
                            end else begin
                                state_next = S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (enable) begin
                        take_bit = 1'b1;
                        if (bit_cnt[2:0] == 3'd7) begin
                            byte_done = 1'b1;
                            if (byte_cnt + LEN_W'(1) == len_q) begin
                                state_next = S_IDLE;
                                frame_end  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len_q       <= '0;
            byte_cnt    <= '0;
            bit_cnt     <= '0;
            asm_q       <= '0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
            service_out <= '0;
            service_err <= 1'b0;
            overflow    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (start) begin
                len_q       <= psdu_len;
                byte_cnt    <= '0;
                bit_cnt     <= '0;
                asm_q       <= '0;
                service_out <= '0;
                service_err <= 1'b0;
                overflow    <= 1'b0;
            end else if (take_bit) begin
                if (state == S_SERVICE) begin
                    service_out[bit_cnt] <= bit_in;
                    if (bit_in && (bit_cnt < CNT_W'(7))) begin
                        service_err <= 1'b1;
                    end
                    bit_cnt <= svc_last ? '0 : bit_cnt + CNT_W'(1);
                end else begin
                    asm_q <= asm_next;
                    if (byte_done) begin
                        bit_cnt  <= '0;
                        byte_cnt <= byte_cnt + LEN_W'(1);
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end

            // a byte finishing in the same cycle as a take replaces the one leaving
            if (byte_done) begin
                if (!valid_q || byte_if.byte_ready) begin
                    byte_q  <= asm_next;
                    valid_q <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (valid_q && byte_if.byte_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign byte_if.byte_out   = byte_q;
    assign byte_if.byte_valid = valid_q;
    assign busy               = (state != S_IDLE);

endmodule

// File: tb/tb_psdu_deframer.sv
// tb/tb_psdu_deframer.sv - Self-checking bench for psdu_deframer.
module tb_psdu_deframer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] psdu_len = '0;
    logic        enable = 1'b0;
    logic        bit_in = 1'b0;
    logic [15:0] service_out;
    logic        service_err;
    logic        overflow;
    logic        busy;
    logic        frame_done;

    psdu_deframer_if dif ();

    psdu_deframer #(.LEN_W(12), .SERVICE_BITS(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .psdu_len    (psdu_len),
        .enable      (enable),
        .bit_in      (bit_in),
        .byte_if     (dif),
        .service_out (service_out),
        .service_err (service_err),
        .overflow    (overflow),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          len;
        logic [15:0] svc;
        logic [31:0] data;
        logic        exp_err;
    } vec_t;

    vec_t       vt[7];
    logic [7:0] tx_q[$];
    logic [7:0] got_q[$];
    int         fd_cnt;
    int         vcycles;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // inputs are set just after an edge; outputs are read 1 time unit after the edge
    task automatic step();
        if (dif.byte_valid && dif.byte_ready) got_q.push_back(dif.byte_out);
        @(posedge clock);
        #1;
        if (frame_done) fd_cnt++;
        if (dif.byte_valid) vcycles++;
    endtask

    function automatic logic [31:0] snap();
        return {3'b0, service_out, service_err, overflow, busy, frame_done,
                dif.byte_valid, dif.byte_out};
    endfunction

    task automatic send_bit(input logic b, input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        enable = 1'b0;
        repeat (g) step();
        enable = 1'b1;
        bit_in = b;
        step();
        enable = 1'b0;
        bit_in = 1'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap_max);
        for (int b = 0; b < 8; b++) send_bit(v[b], gap_max);
    endtask

    task automatic start_frame(input int len);
        got_q.delete();
        fd_cnt   = 0;
        vcycles  = 0;
        psdu_len = 12'(len);
        start    = 1'b1;
        enable   = 1'b1;
        bit_in   = 1'b1;
        step();
        start    = 1'b0;
        enable   = 1'b0;
    endtask

    task automatic run_frame(input int len, input logic [15:0] svc, input int gap_max);
        start_frame(len);
        for (int i = 0; i < 16; i++) send_bit(svc[i], gap_max);
        foreach (tx_q[k]) send_byte(tx_q[k], gap_max);
        step();
        step();
    endtask

    task automatic check_frame(input string tag, input logic [15:0] svc, input logic err);
        check({tag, " service_out"}, 32'(service_out), 32'(svc));
        check({tag, " service_err"}, 32'(service_err), 32'(err));
        check({tag, " overflow"}, 32'(overflow), 32'd0);
        check({tag, " byte count"}, 32'(got_q.size()), 32'(tx_q.size()));
        check({tag, " valid cycles"}, 32'(vcycles), 32'(tx_q.size()));
        check({tag, " frame_done pulses"}, 32'(fd_cnt), 32'd1);
        check({tag, " busy after"}, 32'(busy), 32'd0);
        foreach (tx_q[k]) begin
            if (k < got_q.size()) check({tag, " byte"}, 32'(got_q[k]), 32'(tx_q[k]));
        end
    endtask

    task automatic trail_check(input string tag);
        logic [31:0] s0;
        s0 = snap();
        for (int i = 0; i < 20; i++) send_bit(1'($urandom), 1);
        step();
        check({tag, " trailing bits"}, snap(), s0);
    endtask

    initial begin
        vt[0] = '{2, 16'h0000, 32'h0000_3CA5, 1'b0};
        vt[1] = '{1, 16'h0408, 32'h0000_0042, 1'b1};
        vt[2] = '{0, 16'h8000, 32'h0000_0000, 1'b0};
        vt[3] = '{1, 16'h0040, 32'h0000_007F, 1'b1};
        vt[4] = '{1, 16'h0080, 32'h0000_0080, 1'b0};
        vt[5] = '{3, 16'hFFFF, 32'h0033_2211, 1'b1};
        vt[6] = '{4, 16'h0001, 32'hDEAD_BEEF, 1'b1};
        dif.byte_ready = 1'b1;

        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset outputs", snap(), 32'd0);

        for (int i = 0; i < 7; i++) begin
            tx_q.delete();
            for (int k = 0; k < vt[i].len; k++) tx_q.push_back(vt[i].data[8*k +: 8]);
            run_frame(vt[i].len, vt[i].svc, i % 3);
            check_frame($sformatf("vec%0d", i), vt[i].svc, vt[i].exp_err);
        end

        // zero-length frame: frame_done exactly one cycle after the 16th SERVICE bit
        start_frame(0);
        for (int i = 0; i < 15; i++) send_bit(1'b0, 0);
        check("len0 no early done", 32'(frame_done), 32'd0);
        send_bit(1'b0, 0);
        check("len0 done pulse", 32'(frame_done), 32'd1);
        step();
        check("len0 done cleared", 32'(frame_done), 32'd0);
        check("len0 no valid", 32'(vcycles), 32'd0);

        // back-pressure: second and third bytes are dropped
        dif.byte_ready = 1'b0;
        start_frame(3);
        for (int i = 0; i < 16; i++) send_bit(1'b0, 0);
        send_byte(8'h11, 0);
        check("ovf byte1 valid", 32'(dif.byte_valid), 32'd1);
        check("ovf byte1 flag", 32'(overflow), 32'd0);
        send_byte(8'h22, 1);
        check("ovf byte2 flag", 32'(overflow), 32'd1);
        check("ovf byte2 held", 32'(dif.byte_out), 32'h11);
        send_byte(8'h33, 0);
        check("ovf done pulse", 32'(frame_done), 32'd1);
        check("ovf byte3 held", 32'(dif.byte_out), 32'h11);
        step();
        check("ovf valid held after end", 32'(dif.byte_valid), 32'd1);
        dif.byte_ready = 1'b1;
        step();
        check("ovf drained count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("ovf drained byte", 32'(got_q[0]), 32'h11);
        check("ovf valid cleared", 32'(dif.byte_valid), 32'd0);

        // enable gaps inside a byte, then trailing bits ignored
        tx_q.delete();
        tx_q.push_back(8'hC3);
        run_frame(1, 16'h0000, 4);
        check_frame("gapC3", 16'h0000, 1'b0);
        trail_check("gapC3");

        // reset mid-DATA, then a clean frame
        start_frame(2);
        for (int i = 0; i < 16; i++) send_bit(1'b0, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset outputs", snap(), 32'd0);
        tx_q.delete();
        tx_q.push_back(8'h7E);
        run_frame(1, 16'h0000, 0);
        check_frame("after reset", 16'h0000, 1'b0);

        // randomized frames against the model: bytes out equal bytes in, err = any of first 7 SERVICE bits
        for (int r = 0; r < 8; r++) begin
            logic [15:0] svc;
            int          len;
            len = int'($urandom_range(5, 1));
            svc = 16'($urandom);
            if (r % 2 == 0) svc[6:0] = '0;
            tx_q.delete();
            for (int k = 0; k < len; k++) tx_q.push_back(8'($urandom));
            run_frame(len, svc, int'($urandom_range(3, 0)));
            check_frame($sformatf("rand%0d", r), svc, |svc[6:0]);
            trail_check($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
